// File: rtl/vga_pkg.sv
// Shared VGA timing constants and background tile RAM types.
// Used by the background write scheduler and its FIFO.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] H_TOTAL   = 10'd800;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  localparam int BG_ADDR_W = 10;
  localparam int BG_DATA_W = 24;

  typedef struct packed {
    logic [BG_ADDR_W-1:0] addr;
    logic [BG_DATA_W-1:0] data;
  } bg_wr_t;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_FLUSH
  } sched_state_e;

  // True whenever the beam is outside the visible picture.
  function automatic logic isBlank(input logic [9:0] x, input logic [9:0] y);
    return (x >= H_VISIBLE) || (y >= V_VISIBLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and a flush that overrides push/pop.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  // Flush wins over both push and pop, so a flushed cycle never moves data.
  always_comb begin
    empty_o = (wrPtr_q == rdPtr_q);
    full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    level_o = wrPtr_q - rdPtr_q;
    doPush  = push_i && !full_o && !flush_i;
    doPop   = pop_i && !empty_o && !flush_i;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bg_write_scheduler.sv
// Buffers host writes to the background tile RAM and commits them only in blanking,
// sharing the RAM address port with the renderer; also emits the vblank frame tick.
module bg_write_scheduler
  import vga_pkg::*;
#(
  parameter int GUARD      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic [9:0]                    x_pos,
  input  logic [9:0]                    y_pos,
  input  logic [9:0]                    render_addr,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [9:0]                    wr_addr,
  input  logic [23:0]                   wr_data,
  input  logic                          flush,
  output logic [9:0]                    mem_addr,
  output logic [23:0]                   mem_wdata,
  output logic                          mem_we,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_tick,
  output logic                          busy
);

  localparam logic [9:0] WRITE_END = H_TOTAL - 10'(GUARD);

  sched_state_e state_q, state_d;

  logic        memWe_q, memWe_d;
  logic [9:0]  wrAddr_q, wrAddr_d;
  logic [23:0] wrData_q, wrData_d;
  logic        frameTick_q, frameTick_d;

  logic        writeOk;
  logic        fifoFlush;
  logic        fifoFull, fifoEmpty;
  logic        pushEn, popEn;
  bg_wr_t      pushEntry, headEntry;

  sync_fifo #(
    .WIDTH ($bits(bg_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (vga_clk),
    .reset_i (reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .flush_i (fifoFlush),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .level_o (fifo_level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // The window closes GUARD cycles before line end so the last registered write
  // has retired before the first visible pixel of the next line.
  always_comb begin
    writeOk        = isBlank(x_pos, y_pos) && (x_pos < WRITE_END);
    fifoFlush      = flush || (state_q == ST_FLUSH);
    wr_ready       = !fifoFull && !fifoFlush;
    pushEn         = wr_valid && wr_ready;
    pushEntry.addr = wr_addr;
    pushEntry.data = wr_data;
    popEn          = writeOk && !fifoEmpty && !fifoFlush;
    memWe_d        = popEn;
    wrAddr_d       = popEn ? headEntry.addr : wrAddr_q;
    wrData_d       = popEn ? headEntry.data : wrData_q;
    frameTick_d    = (x_pos == 10'd0) && (y_pos == V_VISIBLE);
  end

  // The pop happens in the same cycle the window opens, so ACTIVE hands off to
  // DRAIN without losing a slot.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (flush)                       state_d = ST_FLUSH;
        else if (writeOk && !fifoEmpty)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flush)                       state_d = ST_FLUSH;
        else if (!writeOk || fifoEmpty)  state_d = ST_ACTIVE;
      end
      ST_FLUSH: begin
        if (flush)                       state_d = ST_FLUSH;
        else                             state_d = ST_ACTIVE;
      end
      default:                           state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q     <= ST_ACTIVE;
      memWe_q     <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      frameTick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      memWe_q     <= memWe_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      frameTick_q <= frameTick_d;
    end
  end

  assign mem_we     = memWe_q;
  assign mem_wdata  = wrData_q;
  assign mem_addr   = memWe_q ? wrAddr_q : render_addr;
  assign frame_tick = frameTick_q;
  assign busy       = !fifoEmpty || memWe_q;

endmodule
